// File: rtl/vreg_req_responder_pkg.sv
// rtl/vreg_req_responder_pkg.sv - shared vector-register request types and constants
package vreg_req_responder_pkg;

    localparam int NUM_OF_LANES      = 4;
    localparam int VECTOR_REG_WIDTH  = 64;
    localparam int NUM_OF_VECTOR_REG = 8;
    localparam int VREG_DEPTH        = 64;
    localparam int VREG_PTR_W        = 5;
    localparam int REQ_ADDR_W        = 32;
    localparam int ACCESS_LEN_W      = 8;

    typedef enum logic [1:0] {
        READ_REQ  = 2'd0,
        WRITE_REQ = 2'd1
    } access_type_t;

    typedef enum logic [1:0] {
        UNIT_STRIDE  = 2'd0,
        CONST_STRIDE = 2'd1,
        INDEXED      = 2'd2
    } stride_type_t;

    typedef logic [VREG_PTR_W-1:0] v_register_t;

    typedef struct packed {
        logic                          vld;
        access_type_t                  access_type;
        logic [ACCESS_LEN_W-1:0]       access_length;
        stride_type_t                  stride_type;
        v_register_t                   vec_reg_ptr;
        logic [REQ_ADDR_W-1:0]         addr;
        logic [VECTOR_REG_WIDTH-1:0]   data;
    } cntrl_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } port_state_t;

endpackage

// File: rtl/vreg_req_responder_if.sv
// rtl/vreg_req_responder_if.sv - request/grant/response bundle between lanes and register file
interface vreg_req_responder_if
    import vreg_req_responder_pkg::*;
#(
    parameter int NUM_PORTS = NUM_OF_LANES
) ();

    cntrl_req_t                    req      [NUM_PORTS];
    logic [NUM_PORTS-1:0]          req_grant;
    logic [NUM_PORTS-1:0]          rsp_vld;
    logic [VECTOR_REG_WIDTH-1:0]   rsp_data [NUM_PORTS];

    modport master (
        output req,
        input  req_grant,
        input  rsp_vld,
        input  rsp_data
    );

    modport slave (
        input  req,
        output req_grant,
        output rsp_vld,
        output rsp_data
    );

endinterface

// File: rtl/vreg_req_responder_arbiter_rr.sv
// rtl/vreg_req_responder_arbiter_rr.sv - round-robin one-hot arbiter, pointer moves past the winner
module arbiter_rr #(
    parameter int VECTOR_IN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VECTOR_IN-1:0] req,
    output logic [VECTOR_IN-1:0] grant
);

    localparam int PW = (VECTOR_IN > 1) ? $clog2(VECTOR_IN) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < VECTOR_IN; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= VECTOR_IN) idx = idx - VECTOR_IN;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = (idx == VECTOR_IN - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vreg_req_responder.sv
// rtl/vreg_req_responder.sv - vector register file answering one-element requests per port
module vreg_req_responder
    import vreg_req_responder_pkg::*;
#(
    parameter int NUM_PORTS         = vreg_req_responder_pkg::NUM_OF_LANES,
    parameter int NUM_OF_VECTOR_REG = vreg_req_responder_pkg::NUM_OF_VECTOR_REG,
    parameter int VREG_DEPTH        = vreg_req_responder_pkg::VREG_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    vreg_req_responder_if.slave  bus
);

    localparam int EW = $clog2(VREG_DEPTH);
    localparam int RW = (NUM_OF_VECTOR_REG > 1) ? $clog2(NUM_OF_VECTOR_REG) : 1;
    localparam int DW = VECTOR_REG_WIDTH;

    logic [DW-1:0] mem [NUM_OF_VECTOR_REG][VREG_DEPTH];

    logic [NUM_PORTS-1:0] wr_req;
    logic [NUM_PORTS-1:0] wr_gnt;
    logic [RW-1:0]        wr_reg  [NUM_PORTS];
    logic [EW-1:0]        wr_elem [NUM_PORTS];
    logic [DW-1:0]        wr_data [NUM_PORTS];

    arbiter_rr #(.VECTOR_IN(NUM_PORTS)) u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_req),
        .grant (wr_gnt)
    );

    // Arbiter grant is one-hot, so at most one port lands here per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_OF_VECTOR_REG; r++)
                for (int e = 0; e < VREG_DEPTH; e++)
                    mem[r][e] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (wr_gnt[p]) mem[wr_reg[p]][wr_elem[p]] <= wr_data[p];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_state_t   state_q;
        port_state_t   state_d;
        cntrl_req_t    cap_q;
        logic          is_write;
        logic          grant_q;
        logic          vld_q;
        logic [DW-1:0] data_q;
        logic [RW-1:0] cap_reg;
        logic [EW-1:0] cap_elem;
        logic          unused_fields;

        assign is_write   = (cap_q.access_type == WRITE_REQ);
        assign cap_reg    = cap_q.vec_reg_ptr[RW-1:0];
        assign cap_elem   = cap_q.addr[EW-1:0];
        assign wr_req[p]  = (state_q == ACCESS) && is_write;
        assign wr_reg[p]  = cap_reg;
        assign wr_elem[p] = cap_elem;
        assign wr_data[p] = cap_q.data;

        assign unused_fields = ^{cap_q.vld, cap_q.access_length, cap_q.stride_type,
                                 cap_q.vec_reg_ptr[VREG_PTR_W-1:RW], cap_q.addr[REQ_ADDR_W-1:EW]};

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (bus.req[p].vld) state_d = ACCESS;
                ACCESS:  if (!is_write || wr_gnt[p]) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Reads sample storage before this cycle's write lands: read-before-write.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cap_q   <= '0;
                grant_q <= 1'b0;
                vld_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                if (state_q == IDLE && bus.req[p].vld) cap_q <= bus.req[p];
                grant_q <= (state_q == ACCESS) && (!is_write || wr_gnt[p]);
                vld_q   <= (state_q == ACCESS) && !is_write;
                if (state_q == ACCESS && !is_write) data_q <= mem[cap_reg][cap_elem];
            end
        end

        assign bus.req_grant[p] = grant_q;
        assign bus.rsp_vld[p]   = vld_q;
        assign bus.rsp_data[p]  = data_q;
    end

endmodule

// File: tb/tb_vreg_req_responder.sv
// tb/tb_vreg_req_responder.sv - randomized self-checking bench with a transaction-level register model
module tb_vreg_req_responder;
    import vreg_req_responder_pkg::*;

    localparam int NP = 4;
    localparam int NR = 8;
    localparam int ND = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vreg_req_responder_if #(.NUM_PORTS(NP)) bus ();

    vreg_req_responder #(
        .NUM_PORTS         (NP),
        .NUM_OF_VECTOR_REG (NR),
        .VREG_DEPTH        (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]  mdl [NR][ND];
    int           rr_ptr;
    logic [63:0]  last_rsp [NP];

    bit           t_act  [NP];
    access_type_t t_type [NP];
    logic [4:0]   t_reg  [NP];
    logic [31:0]  t_addr [NP];
    logic [63:0]  t_data [NP];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++)
            for (int e = 0; e < ND; e++)
                mdl[r][e] = '0;
        rr_ptr = 0;
        for (int p = 0; p < NP; p++) last_rsp[p] = '0;
    endtask

    task automatic clr_all();
        for (int p = 0; p < NP; p++) t_act[p] = 1'b0;
    endtask

    task automatic set_req(input int p, input access_type_t t, input int r,
                           input logic [31:0] a, input logic [63:0] d);
        t_act[p]  = 1'b1;
        t_type[p] = t;
        t_reg[p]  = 5'(r);
        t_addr[p] = a;
        t_data[p] = d;
    endtask

    task automatic drop_bus();
        for (int p = 0; p < NP; p++) bus.req[p] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s p%0d grant", tag, p), 64'(bus.req_grant[p]), 64'd0);
            chk($sformatf("%s p%0d rsp_vld", tag, p), 64'(bus.rsp_vld[p]), 64'd0);
            chk($sformatf("%s p%0d rsp_data", tag, p), bus.rsp_data[p], last_rsp[p]);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drop_bus();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    // Every active port fires together from IDLE; reads see the pre-round storage,
    // writes retire one per cycle in cyclic order starting at the arbiter pointer.
    task automatic run_round();
        int          exp_cyc [NP];
        logic [63:0] exp_d   [NP];
        int          k, last, maxc, p;
        cntrl_req_t  r;
        for (int q = 0; q < NP; q++) begin
            exp_cyc[q] = 0;
            exp_d[q]   = '0;
            if (t_act[q] && t_type[q] != WRITE_REQ) begin
                exp_cyc[q] = 2;
                exp_d[q]   = mdl[t_reg[q] % NR][t_addr[q] % ND];
            end
        end
        k = 0;
        last = -1;
        for (int i = 0; i < NP; i++) begin
            p = (rr_ptr + i) % NP;
            if (t_act[p] && t_type[p] == WRITE_REQ) begin
                exp_cyc[p] = 2 + k;
                k++;
                mdl[t_reg[p] % NR][t_addr[p] % ND] = t_data[p];
                last = p;
            end
        end
        if (last >= 0) rr_ptr = (last + 1) % NP;
        maxc = k + 3;

        @(negedge clk);
        for (int q = 0; q < NP; q++) begin
            r               = '0;
            r.vld           = t_act[q];
            r.access_type   = t_type[q];
            r.access_length = 8'($urandom);
            r.stride_type   = stride_type_t'(2'($urandom_range(0, 3)));
            r.vec_reg_ptr   = t_reg[q];
            r.addr          = t_addr[q];
            r.data          = t_data[q];
            bus.req[q]      = r;
        end
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            for (int q = 0; q < NP; q++) begin
                logic eg, ev;
                eg = (exp_cyc[q] == c);
                ev = eg && (t_type[q] != WRITE_REQ);
                if (ev) last_rsp[q] = exp_d[q];
                chk($sformatf("p%0d c%0d grant", q, c), 64'(bus.req_grant[q]), 64'(eg));
                chk($sformatf("p%0d c%0d rsp_vld", q, c), 64'(bus.rsp_vld[q]), 64'(ev));
                chk($sformatf("p%0d c%0d rsp_data", q, c), bus.rsp_data[q], last_rsp[q]);
                if (eg) bus.req[q].vld = 1'b0;
            end
        end
        clr_all();
    endtask

    initial begin
        reset = 1'b0;
        drop_bus();
        clr_all();
        model_clear();
        apply_reset();

        // Read of a freshly reset element.
        set_req(0, READ_REQ, 3, 32'd5, '0);
        run_round();

        // Write then read back on port 1.
        set_req(1, WRITE_REQ, 2, 32'd7, 64'hDEAD_BEEF_0000_0001);
        run_round();
        set_req(1, READ_REQ, 2, 32'd7, '0);
        run_round();

        // Three-way write contention from a fresh pointer, then read the survivor.
        apply_reset();
        set_req(0, WRITE_REQ, 0, 32'd0, 64'hA);
        set_req(1, WRITE_REQ, 0, 32'd0, 64'hB);
        set_req(2, WRITE_REQ, 0, 32'd0, 64'hC);
        run_round();
        set_req(3, READ_REQ, 0, 32'd0, '0);
        run_round();

        // Seed some contents, then four parallel reads.
        for (int q = 0; q < NP; q++) set_req(q, WRITE_REQ, q + 3, 32'(q * 5), 64'(32'h1000 + q));
        run_round();
        for (int q = 0; q < NP; q++) set_req(q, READ_REQ, q + 3, 32'(q * 5), '0);
        run_round();

        // Element index wraps modulo depth.
        set_req(2, WRITE_REQ, 1, 32'd70, 64'h55);
        run_round();
        set_req(0, READ_REQ, 1, 32'd6, '0);
        run_round();

        // Same-cycle read and write of one element.
        set_req(0, WRITE_REQ, 4, 32'd9, 64'h1);
        run_round();
        set_req(0, READ_REQ, 4, 32'd9, '0);
        set_req(1, WRITE_REQ, 4, 32'd9, 64'h2);
        run_round();
        set_req(3, READ_REQ, 4, 32'd9, '0);
        run_round();

        // Non-read/write access types behave as reads.
        set_req(1, access_type_t'(2'd2), 4, 32'd9, 64'hFFFF);
        set_req(2, access_type_t'(2'd3), 1, 32'd134, 64'hFFFF);
        run_round();

        // Reset while port 2 still waits on a losing write.
        apply_reset();
        set_req(0, WRITE_REQ, 5, 32'd0, 64'h77);
        set_req(2, WRITE_REQ, 5, 32'd1, 64'h99);
        @(negedge clk);
        for (int q = 0; q < NP; q++) begin
            bus.req[q]             = '0;
            bus.req[q].vld         = t_act[q];
            bus.req[q].access_type = t_type[q];
            bus.req[q].vec_reg_ptr = t_reg[q];
            bus.req[q].addr        = t_addr[q];
            bus.req[q].data        = t_data[q];
        end
        @(negedge clk);
        chk("abort c1 p0 grant", 64'(bus.req_grant[0]), 64'd0);
        chk("abort c1 p2 grant", 64'(bus.req_grant[2]), 64'd0);
        @(negedge clk);
        chk("abort c2 p0 grant", 64'(bus.req_grant[0]), 64'd1);
        chk("abort c2 p2 grant", 64'(bus.req_grant[2]), 64'd0);
        reset = 1'b0;
        drop_bus();
        clr_all();
        #1;
        model_clear();
        check_idle_outputs("abort in reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort after c%0d p2 grant", c), 64'(bus.req_grant[2]), 64'd0);
        end
        set_req(0, READ_REQ, 5, 32'd0, '0);
        set_req(2, READ_REQ, 5, 32'd1, '0);
        run_round();

        // Randomized rounds with deliberately clustered addresses to provoke collisions.
        for (int n = 0; n < 200; n++) begin
            for (int q = 0; q < NP; q++) begin
                if ($urandom_range(0, 3) != 0) begin
                    logic [31:0] a;
                    a = $urandom();
                    a[5:0] = 6'($urandom_range(0, 3));
                    set_req(q, access_type_t'(2'($urandom_range(0, 3))),
                            int'({2'($urandom_range(0, 3)), 3'($urandom_range(0, 1))}),
                            a, {$urandom(), $urandom()});
                end
            end
            run_round();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
